// File: rtl/half_adder_core.sv
// Multi-lane half adder: per lane {carry, sum} = a + b.
// Optionally registered with one-cycle latency and a valid qualifier.
module half_adder_core #(
  parameter int unsigned LANES      = 1,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_a,
  input  logic [LANES-1:0] in_b,
  output logic [LANES-1:0] out_s,
  output logic [LANES-1:0] out_c,
  output logic             out_valid
);

  logic [LANES-1:0] sum_w;
  logic [LANES-1:0] carry_w;

  // Lanes are independent: no carry ripples between bits.
  assign sum_w   = in_a ^ in_b;
  assign carry_w = in_a & in_b;

  if (REGISTERED) begin : g_reg
    logic [LANES-1:0] s_d, s_q;
    logic [LANES-1:0] c_d, c_q;
    logic             valid_d, valid_q;

    always_comb begin
      s_d     = s_q;
      c_d     = c_q;
      valid_d = in_valid;
      if (in_valid) begin
        s_d = sum_w;
        c_d = carry_w;
      end
    end

    // Reset wins over in_valid so an in-flight result is dropped.
    always_ff @(posedge in_clk) begin
      if (in_rst) begin
        s_q     <= '0;
        c_q     <= '0;
        valid_q <= 1'b0;
      end else begin
        s_q     <= s_d;
        c_q     <= c_d;
        valid_q <= valid_d;
      end
    end

    assign out_s     = s_q;
    assign out_c     = c_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = in_clk ^ in_rst;

    assign out_s     = sum_w;
    assign out_c     = carry_w;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_half_adder_core.sv
// Scoreboard bench: 1-lane and 4-lane registered instances plus a 4-lane combinational one.
module tb_half_adder_core;

  typedef struct packed {
    logic       v;
    logic [3:0] c;
    logic [3:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, valid;
  logic       a1, b1;
  logic [3:0] a4, b4;
  logic       s1, c1, v1;
  logic [3:0] s4, c4;
  logic       v4;
  logic [3:0] sc, cc;
  logic       vc;

  int n_total = 0;
  int n_bad   = 0;

  exp_t q1[$];
  exp_t q4[$];
  exp_t m1 = '0;
  exp_t m4 = '0;
  bit   known = 1'b0;

  always #5 clk = ~clk;

  half_adder_core #(.LANES(1), .REGISTERED(1'b1)) u_dut1 (
    .in_clk(clk), .in_rst(rst), .in_valid(valid), .in_a(a1), .in_b(b1),
    .out_s(s1), .out_c(c1), .out_valid(v1)
  );

  half_adder_core #(.LANES(4), .REGISTERED(1'b1)) u_dut4 (
    .in_clk(clk), .in_rst(rst), .in_valid(valid), .in_a(a4), .in_b(b4),
    .out_s(s4), .out_c(c4), .out_valid(v4)
  );

  half_adder_core #(.LANES(4), .REGISTERED(1'b0)) u_dutc (
    .in_clk(clk), .in_rst(rst), .in_valid(valid), .in_a(a4), .in_b(b4),
    .out_s(sc), .out_c(cc), .out_valid(vc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Per-lane arithmetic sum, returned as {carry[3:0], sum[3:0]}.
  function automatic logic [7:0] add_lanes(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] t;
    logic [3:0] c, s;
    for (int i = 0; i < 4; i++) begin
      t    = {1'b0, a[i]} + {1'b0, b[i]};
      c[i] = t[1];
      s[i] = t[0];
    end
    return {c, s};
  endfunction

  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] cs4;
    logic [1:0] cs1;
    exp_t       p1, p4, e;
    p1 = m1;
    p4 = m4;
    rst   = r;
    valid = v;
    a4    = a;
    b4    = b;
    a1    = a[0];
    b1    = b[0];
    cs4   = add_lanes(a, b);
    cs1   = {1'b0, a[0]} + {1'b0, b[0]};
    if (r) begin
      m1 = '0;
      m4 = '0;
    end else begin
      m1.v = v;
      m4.v = v;
      if (v) begin
        m4.c = cs4[7:4];
        m4.s = cs4[3:0];
        m1.c = {3'b000, cs1[1]};
        m1.s = {3'b000, cs1[0]};
      end
    end
    q1.push_back(m1);
    q4.push_back(m4);
    #1;
    check("comb_s", 32'(sc), 32'(cs4[3:0]));
    check("comb_c", 32'(cc), 32'(cs4[7:4]));
    check("comb_valid", 32'(vc), 32'(v));
    if (known) begin
      // Registered outputs must ignore input changes between edges.
      check("hold4", 32'({v4, c4, s4}), 32'(p4));
      check("hold1", 32'({v1, c1, s1}), 32'({p1.v, p1.c[0], p1.s[0]}));
    end
    @(posedge clk);
    #1;
    if (q4.size() == 0 || q1.size() == 0) begin
      check("scoreboard_empty", 32'(q4.size() + q1.size()), 32'd2);
    end else begin
      e = q4.pop_front();
      check("reg4", 32'({v4, c4, s4}), 32'(e));
      e = q1.pop_front();
      check("reg1", 32'({v1, c1, s1}), 32'({e.v, e.c[0], e.s[0]}));
    end
    known = 1'b1;
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rv;

    // Reset, with in_valid high to show reset wins.
    step(1'b1, 1'b1, 4'hF, 4'hF);
    step(1'b1, 1'b1, 4'hF, 4'hF);
    check("rst_out", 32'({v1, c1, s1}), 32'd0);

    // Truth table on lane 0.
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    check("tt_00", 32'({v1, c1, s1}), 32'b100);
    step(1'b0, 1'b1, 4'b0000, 4'b0001);
    check("tt_01", 32'({v1, c1, s1}), 32'b101);
    step(1'b0, 1'b1, 4'b0001, 4'b0000);
    check("tt_10", 32'({v1, c1, s1}), 32'b101);
    step(1'b0, 1'b1, 4'b0001, 4'b0001);
    check("tt_11", 32'({v1, c1, s1}), 32'b110);

    // Multi-lane independence.
    step(1'b0, 1'b1, 4'b1100, 4'b1010);
    check("ml_s", 32'(s4), 32'b0110);
    check("ml_c", 32'(c4), 32'b1000);

    // Valid gating: outputs hold while out_valid drops.
    step(1'b0, 1'b1, 4'b0001, 4'b0001);
    step(1'b0, 1'b0, 4'b0000, 4'b0000);
    check("gate", 32'({v1, c1, s1}), 32'b010);

    // Reset mid-operation, then release.
    step(1'b0, 1'b1, 4'b1111, 4'b1111);
    step(1'b1, 1'b1, 4'b1111, 4'b1111);
    check("midrst", 32'({v4, c4, s4}), 32'd0);
    step(1'b0, 1'b1, 4'b0000, 4'b0001);
    check("release", 32'({v1, c1, s1}), 32'b101);

    // Random back-to-back vectors.
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      step(1'b0, rv, ra, rb);
      if (rv) check("rand_sum", 32'({c1, s1}), 32'({1'b0, ra[0]} + {1'b0, rb[0]}));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
